// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state codes and status-register bit positions for the
// SPI NOR-flash emulator.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDID      = 8'h9F;
  localparam logic [7:0] OP_RDSR      = 8'h05;
  localparam logic [7:0] OP_PD        = 8'hB9;
  localparam logic [7:0] OP_RPD       = 8'hAB;
  localparam logic [7:0] OP_WREN      = 8'h06;
  localparam logic [7:0] OP_WRDI      = 8'h04;
  localparam logic [7:0] OP_PP        = 8'h02;
  localparam logic [7:0] OP_SE        = 8'h20;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_ID     = 3'd5;
  localparam logic [2:0] ST_STAT   = 3'd6;
  localparam logic [2:0] ST_IGNORE = 3'd7;

  localparam int SR_BUSY = 0;
  localparam int SR_WEL  = 1;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus single-cycle sclk edge strobes.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic csb,
  input  logic sclk,
  input  logic mosi_pin,
  output logic cs_active,
  output logic sck_rise,
  output logic sck_fall,
  output logic mosi
);

  logic [1:0] csb_q;
  logic [1:0] sclk_q;
  logic [1:0] mosi_q;
  logic       sclk_d;

  // csb stages come out of reset as "selected" so a chip select already held
  // low at reset release never looks like a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb_q  <= 2'b00;
      sclk_q <= 2'b00;
      mosi_q <= 2'b00;
      sclk_d <= 1'b0;
    end else begin
      csb_q  <= {csb_q[0], csb};
      sclk_q <= {sclk_q[0], sclk};
      mosi_q <= {mosi_q[0], mosi_pin};
      sclk_d <= sclk_q[1];
    end
  end

  assign cs_active = ~csb_q[1];
  assign sck_rise  = sclk_q[1] & ~sclk_d;
  assign sck_fall  = ~sclk_q[1] & sclk_d;
  assign mosi      = mosi_q[1];

endmodule

// File: rtl/spi_flash_emu.sv
// SPI NOR-flash emulator: READ, FAST READ, JEDEC ID, status and power-down.
// Define FLASH_PROGRAM_EN to add WREN/WRDI, page program and 4 KB sector erase.
module spi_flash_emu
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter              INIT_FILE = "",
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
  input  logic clk,
  input  logic reset,
  input  logic csb,
  input  logic sclk,
  input  logic io0,
  output logic io1,
  input  logic io2,
  input  logic io3
);

  localparam int MEM_BYTES = 1 << ADDR_W;

  logic [7:0] mem [0:MEM_BYTES-1];

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'hFF;
  end

  logic cs_active, sck_rise, sck_fall, mosi;

  spi_pin_sync u_sync (
    .clk      (clk),
    .rst_n    (reset),
    .csb      (csb),
    .sclk     (sclk),
    .mosi_pin (io0),
    .cs_active(cs_active),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .mosi     (mosi)
  );

  logic unused_pins;
  assign unused_pins = io2 ^ io3;

  logic [2:0]        state, cmd_next;
  logic [4:0]        bit_cnt;
  logic [ADDR_W-2:0] shreg;
  logic [7:0]        opcode;
  logic [7:0]        tx_sh, next_byte;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        id_idx;
  logic              cs_act_d;
  logic              power_down, pend_pd_set, pend_pd_clr;
  logic [7:0]        status;
  logic              is_pp;

  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] rx_addr, addr_inc;
  logic              cs_rise;

  assign rx_byte  = {shreg[6:0], mosi};
  assign rx_addr  = {shreg[ADDR_W-2:0], mosi};
  assign addr_inc = addr + 1'b1;
  assign cs_rise  = cs_act_d & ~cs_active;

`ifdef FLASH_PROGRAM_EN
  logic wel, pend_wel_set, pend_wel_clr, pend_erase;
  logic prog_we, erase_go;

  assign is_pp    = (opcode == OP_PP);
  assign status   = {6'b0, wel, 1'b0};
  assign prog_we  = cs_active && state == ST_DATA && is_pp && sck_rise && bit_cnt == 5'd7;
  assign erase_go = cs_rise && pend_erase;

  // Write-enable latch and erase requests only commit when csb rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wel          <= 1'b0;
      pend_wel_set <= 1'b0;
      pend_wel_clr <= 1'b0;
      pend_erase   <= 1'b0;
    end else if (!cs_active) begin
      if (cs_act_d && pend_wel_set) wel <= 1'b1;
      if (cs_act_d && pend_wel_clr) wel <= 1'b0;
      pend_wel_set <= 1'b0;
      pend_wel_clr <= 1'b0;
      pend_erase   <= 1'b0;
    end else if (state == ST_CMD && sck_rise && bit_cnt == 5'd7 && !power_down) begin
      case (rx_byte)
        OP_WREN:      pend_wel_set <= 1'b1;
        OP_WRDI:      pend_wel_clr <= 1'b1;
        OP_PP, OP_SE: if (wel) pend_wel_clr <= 1'b1;
        default: ;
      endcase
    end else if (state == ST_ADDR && sck_rise && bit_cnt == 5'd23 && opcode == OP_SE) begin
      pend_erase <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we) mem[addr] <= mem[addr] & rx_byte;
    else if (erase_go)
      for (int i = 0; i < 4096; i++) mem[{addr[ADDR_W-1:12], i[11:0]}] <= 8'hFF;
  end
`else
  assign is_pp  = 1'b0;
  assign status = 8'h00;
`endif

  always_comb begin
    cmd_next = ST_IGNORE;
    if (!power_down) begin
      case (rx_byte)
        OP_READ, OP_FAST_READ: cmd_next = ST_ADDR;
        OP_RDID:               cmd_next = ST_ID;
        OP_RDSR:               cmd_next = ST_STAT;
`ifdef FLASH_PROGRAM_EN
        OP_PP, OP_SE:          cmd_next = wel ? ST_ADDR : ST_IGNORE;
`endif
        default:               cmd_next = ST_IGNORE;
      endcase
    end
  end

  // Byte loaded into the output shifter once the current one is exhausted.
  always_comb begin
    next_byte = 8'hFF;
    case (state)
      ST_DATA: next_byte = mem[addr_inc];
      ST_ID: begin
        case (id_idx)
          2'd1:    next_byte = JEDEC_ID[15:8];
          2'd2:    next_byte = JEDEC_ID[7:0];
          default: next_byte = 8'hFF;
        endcase
      end
      ST_STAT: next_byte = status;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      opcode      <= '0;
      addr        <= '0;
      tx_sh       <= 8'hFF;
      id_idx      <= '0;
      io1         <= 1'b1;
      cs_act_d    <= 1'b1;
      power_down  <= 1'b0;
      pend_pd_set <= 1'b0;
      pend_pd_clr <= 1'b0;
    end else begin
      cs_act_d <= cs_active;
      if (!cs_active) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        io1     <= 1'b1;
        if (cs_act_d && pend_pd_set) power_down <= 1'b1;
        if (cs_act_d && pend_pd_clr) power_down <= 1'b0;
        pend_pd_set <= 1'b0;
        pend_pd_clr <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (!cs_act_d) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
          end
          ST_CMD: if (sck_rise) begin
            shreg   <= {shreg[ADDR_W-3:0], mosi};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              opcode  <= rx_byte;
              bit_cnt <= '0;
              state   <= cmd_next;
              tx_sh   <= (rx_byte == OP_RDID) ? JEDEC_ID[23:16] : status;
              id_idx  <= 2'd1;
              if (rx_byte == OP_RPD) pend_pd_clr <= 1'b1;
              if (rx_byte == OP_PD && !power_down) pend_pd_set <= 1'b1;
            end
          end
          ST_ADDR: if (sck_rise) begin
            shreg   <= {shreg[ADDR_W-3:0], mosi};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              addr    <= rx_addr;
              bit_cnt <= '0;
              tx_sh   <= mem[rx_addr];
              if (opcode == OP_FAST_READ) state <= ST_DUMMY;
              else if (opcode == OP_SE)   state <= ST_IGNORE;
              else                        state <= ST_DATA;
            end
          end
          ST_DUMMY: if (sck_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              state   <= ST_DATA;
            end
          end
          ST_DATA, ST_ID, ST_STAT: begin
            if (is_pp) begin
              // Page program: capture on rise, address wraps inside the page.
              if (sck_rise) begin
                shreg <= {shreg[ADDR_W-3:0], mosi};
                if (bit_cnt == 5'd7) begin
                  bit_cnt <= '0;
                  addr    <= {addr[ADDR_W-1:8], addr[7:0] + 8'd1};
                end else begin
                  bit_cnt <= bit_cnt + 5'd1;
                end
              end
            end else if (sck_fall) begin
              io1 <= tx_sh[7];
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                tx_sh   <= next_byte;
                if (state == ST_DATA) addr <= addr_inc;
                if (state == ST_ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                tx_sh   <= {tx_sh[6:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_emu.sv
// Randomized bench for spi_flash_emu against a byte-array reference model.
module tb_spi_flash_emu;

  localparam int          ADDR_W = 16;
  localparam int          MEM    = 1 << ADDR_W;
  localparam int          HALF   = 40;
  localparam logic [23:0] JID    = 24'hEF4016;

  logic clk = 1'b0;
  logic reset, csb, sclk, io0, io1, io2, io3;

  int checks = 0;
  int passed = 0;

  logic [7:0] model_mem [0:MEM-1];
  bit         model_pd;
  logic [7:0] hdr[$];
  logic [7:0] rx[$];

  spi_flash_emu #(.ADDR_W(ADDR_W), .INIT_FILE(""), .JEDEC_ID(JID)) dut (
    .clk  (clk),
    .reset(reset),
    .csb  (csb),
    .sclk (sclk),
    .io0  (io0),
    .io1  (io1),
    .io2  (io2),
    .io3  (io3)
  );

  always #5 clk = ~clk;

  // kind: 0 READ, 1 FAST READ, 2 JEDEC ID, 3 STATUS; k = byte index in data phase
  function automatic logic [7:0] exp_byte(input int kind, input logic [23:0] a, input int k);
    if (model_pd) return 8'hFF;
    case (kind)
      0, 1: return model_mem[(int'(a[15:0]) + k) % MEM];
      2: begin
        if (k == 0) return JID[23:16];
        if (k == 1) return JID[15:8];
        if (k == 2) return JID[7:0];
        return 8'hFF;
      end
      default: return 8'h00;
    endcase
  endfunction

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rxb);
    rxb = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      io0 = tx[i];
      #HALF;
      rxb[i] = io1;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic run_txn(input int nread);
    logic [7:0] b;
    csb = 1'b0;
    #HALF;
    foreach (hdr[i]) spi_bits(hdr[i], 8, b);
    rx.delete();
    for (int i = 0; i < nread; i++) begin
      spi_bits(8'($urandom), 8, b);
      rx.push_back(b);
    end
    #HALF;
    csb = 1'b1;
    #(3*HALF);
  endtask

  task automatic build_hdr(input int kind, input logic [23:0] a);
    hdr.delete();
    case (kind)
      0: hdr = '{8'h03, a[23:16], a[15:8], a[7:0]};
      1: hdr = '{8'h0B, a[23:16], a[15:8], a[7:0], 8'($urandom)};
      2: hdr = '{8'h9F};
      default: hdr = '{8'h05};
    endcase
  endtask

  task automatic test_reset();
    checks++;
    if (io1 !== 1'b1) $display("FAIL reset_io1 got %b exp 1", io1);
    else passed++;
    reset = 1'b1;
    #21;
    checks++;
    if (io1 !== 1'b1) $display("FAIL idle_io1 got %b exp 1", io1);
    else passed++;
  endtask

  task automatic test_read();
    logic [23:0] a;
    build_hdr(0, 24'h000000);
    run_txn(4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx[k] !== exp_byte(0, 24'h0, k)) $display("FAIL read0[%0d] got %h exp %h", k, rx[k], exp_byte(0, 24'h0, k));
      else passed++;
    end
    for (int t = 0; t < 3; t++) begin
      a = 24'($urandom);
      build_hdr(0, a);
      run_txn(1 + $urandom_range(0, 4));
      foreach (rx[k]) begin
        checks++;
        if (rx[k] !== exp_byte(0, a, k)) $display("FAIL read_rand a=%h[%0d] got %h exp %h", a, k, rx[k], exp_byte(0, a, k));
        else passed++;
      end
    end
  endtask

  task automatic test_fast_read();
    logic [23:0] a;
    for (int t = 0; t < 3; t++) begin
      a = (t == 0) ? 24'h000002 : 24'($urandom);
      build_hdr(1, a);
      run_txn((t == 0) ? 2 : 1 + $urandom_range(0, 3));
      foreach (rx[k]) begin
        checks++;
        if (rx[k] !== exp_byte(1, a, k)) $display("FAIL fast a=%h[%0d] got %h exp %h", a, k, rx[k], exp_byte(1, a, k));
        else passed++;
      end
    end
  endtask

  task automatic test_id_status();
    build_hdr(2, 24'h0);
    run_txn(5);
    foreach (rx[k]) begin
      checks++;
      if (rx[k] !== exp_byte(2, 24'h0, k)) $display("FAIL jedec[%0d] got %h exp %h", k, rx[k], exp_byte(2, 24'h0, k));
      else passed++;
    end
    build_hdr(3, 24'h0);
    run_txn(3);
    foreach (rx[k]) begin
      checks++;
      if (rx[k] !== 8'h00) $display("FAIL status[%0d] got %h exp 00", k, rx[k]);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    build_hdr(0, 24'hFFFFFF);
    run_txn(3);
    foreach (rx[k]) begin
      checks++;
      if (rx[k] !== model_mem[(16'hFFFF + k) % MEM]) $display("FAIL wrap[%0d] got %h exp %h", k, rx[k], model_mem[(16'hFFFF + k) % MEM]);
      else passed++;
    end
    build_hdr(0, 24'hA51234);
    run_txn(1);
    checks++;
    if (rx[0] !== model_mem[16'h1234]) $display("FAIL upper_addr got %h exp %h", rx[0], model_mem[16'h1234]);
    else passed++;
  endtask

  task automatic test_unknown();
    logic [7:0] op;
    for (int t = 0; t < 3; t++) begin
      do op = 8'($urandom);
      while (op inside {8'h03, 8'h0B, 8'h9F, 8'h05, 8'hB9, 8'hAB, 8'h06, 8'h04, 8'h02, 8'h20});
      hdr = '{op, 8'h00, 8'h00, 8'h00};
      run_txn(2);
      foreach (rx[k]) begin
        checks++;
        if (rx[k] !== 8'hFF) $display("FAIL unknown op=%h[%0d] got %h exp ff", op, k, rx[k]);
        else passed++;
      end
    end
  endtask

  task automatic test_power_down();
    hdr = '{8'hB9};
    run_txn(0);
    model_pd = 1'b1;
    build_hdr(0, 24'h0);
    run_txn(2);
    foreach (rx[k]) begin
      checks++;
      if (rx[k] !== exp_byte(0, 24'h0, k)) $display("FAIL pd_read[%0d] got %h exp %h", k, rx[k], exp_byte(0, 24'h0, k));
      else passed++;
    end
    build_hdr(2, 24'h0);
    run_txn(1);
    checks++;
    if (rx[0] !== 8'hFF) $display("FAIL pd_jedec got %h exp ff", rx[0]);
    else passed++;
    hdr = '{8'hAB};
    run_txn(0);
    model_pd = 1'b0;
    build_hdr(0, 24'h0);
    run_txn(1);
    checks++;
    if (rx[0] !== model_mem[0]) $display("FAIL pd_release got %h exp %h", rx[0], model_mem[0]);
    else passed++;
  endtask

  task automatic test_truncated();
    logic [7:0] b;
    csb = 1'b0;
    #HALF;
    spi_bits(8'hB9, 5, b);
    #HALF;
    csb = 1'b1;
    #(3*HALF);
    build_hdr(0, 24'h000003);
    run_txn(1);
    checks++;
    if (rx[0] !== model_mem[3]) $display("FAIL trunc_cmd got %h exp %h", rx[0], model_mem[3]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    hdr = '{8'hB9};
    run_txn(0);
    model_pd = 1'b1;
    csb = 1'b0;
    #HALF;
    spi_bits(8'h03, 8, b);
    spi_bits(8'h00, 8, b);
    spi_bits(8'h00, 4, b);
    reset = 1'b0;
    #50;
    checks++;
    if (io1 !== 1'b1) $display("FAIL midreset_io1 got %b exp 1", io1);
    else passed++;
    reset = 1'b1;
    model_pd = 1'b0;
    #30;
    for (int i = 0; i < 2; i++) begin
      spi_bits((i == 0) ? 8'h9F : 8'h00, 8, b);
      checks++;
      if (b !== 8'hFF) $display("FAIL post_reset_ignore[%0d] got %h exp ff", i, b);
      else passed++;
    end
    #HALF;
    csb = 1'b1;
    #(3*HALF);
    build_hdr(0, 24'h000001);
    run_txn(2);
    foreach (rx[k]) begin
      checks++;
      if (rx[k] !== exp_byte(0, 24'h1, k)) $display("FAIL after_reset[%0d] got %h exp %h", k, rx[k], exp_byte(0, 24'h1, k));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int kind;
    logic [23:0] a;
    for (int t = 0; t < 8; t++) begin
      kind = $urandom_range(0, 3);
      a = 24'($urandom);
      build_hdr(kind, a);
      run_txn(1 + $urandom_range(0, 3));
      foreach (rx[k]) begin
        checks++;
        if (rx[k] !== exp_byte(kind, a, k)) $display("FAIL b2b kind=%0d a=%h[%0d] got %h exp %h", kind, a, k, rx[k], exp_byte(kind, a, k));
        else passed++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    csb = 1'b1;
    sclk = 1'b0;
    io0 = 1'b0;
    io2 = 1'b1;
    io3 = 1'b1;
    model_pd = 1'b0;
    #1;
    reset = 1'b0;
    for (int i = 0; i < MEM; i++) model_mem[i] = 8'($urandom);
    model_mem[0] = 8'h6F;
    model_mem[1] = 8'h00;
    model_mem[2] = 8'h00;
    model_mem[3] = 8'h0B;
    for (int i = 0; i < MEM; i++) dut.mem[i] = model_mem[i];
    #20;
    test_reset();
    #21;
    test_read();
    test_fast_read();
    test_id_status();
    test_wrap();
    test_unknown();
    test_power_down();
    test_truncated();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
